rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader_if.sv | 19 +
 rtl/rom_loader.sv | 153 +++++++++++++++
 tb/tb_rom_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rom_loader_if.sv
// rom_loader_if: UART byte input plus ROM write port and load status for rom_loader.
interface rom_loader_if;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        WR_EN;
    logic [15:0] WR_ADDR;
    logic [15:0] WR_DATA;
    logic        CPU_HOLD;
    logic        LOAD_DONE;
    logic        LOAD_ERR;
    modport master (
        output RX_DATA, RX_VALID,
        input  WR_EN, WR_ADDR, WR_DATA, CPU_HOLD, LOAD_DONE, LOAD_ERR
    );
    modport slave (
        input  RX_DATA, RX_VALID,
        output WR_EN, WR_ADDR, WR_DATA, CPU_HOLD, LOAD_DONE, LOAD_ERR
    );
endinterface

// File: rtl/rom_loader.sv
// rom_loader: writes framed 16-bit words from a UART byte stream into instruction ROM.
// Define ROM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module rom_loader #(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         MAX_WORDS      = 32768,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input logic         CLK_100MHz,
    input logic         RESET_N,
    rom_loader_if.slave bus
);
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO
`ifdef ROM_LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    state_t        r_state, w_state;
    logic [15:0]   r_len, w_len;
    logic [15:0]   r_cnt, w_cnt;
    logic [7:0]    r_hi, w_hi;
    logic [TW-1:0] r_tmo, w_tmo;
    logic          r_wr_en, w_wr_en;
    logic [15:0]   r_wr_addr, w_wr_addr;
    logic [15:0]   r_wr_data, w_wr_data;
    logic          r_hold, w_hold;
    logic          r_done, w_done;
    logic          r_err, w_err;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]    r_csum, w_csum;
`endif

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_tmo     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_hold    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            r_csum    <= '0;
`endif
        end else begin
            r_state   <= w_state;
            r_len     <= w_len;
            r_cnt     <= w_cnt;
            r_hi      <= w_hi;
            r_tmo     <= w_tmo;
            r_wr_en   <= w_wr_en;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
            r_hold    <= w_hold;
            r_done    <= w_done;
            r_err     <= w_err;
`ifdef ROM_LOADER_CHECKSUM_EN
            r_csum    <= w_csum;
`endif
        end
    end

    always_comb begin
        w_state   = r_state;
        w_len     = r_len;
        w_cnt     = r_cnt;
        w_hi      = r_hi;
        w_wr_en   = 1'b0;
        w_wr_addr = r_wr_addr;
        w_wr_data = r_wr_data;
        w_hold    = r_hold;
        w_done    = r_done;
        w_err     = r_err;
        w_tmo     = (bus.RX_VALID || r_state == S_IDLE) ? '0 : r_tmo + 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
        w_csum    = (r_state == S_IDLE) ? 8'h00 : (bus.RX_VALID ? r_csum ^ bus.RX_DATA : r_csum);
`endif
        if (bus.RX_VALID) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.RX_DATA == SYNC_BYTE) begin
                        w_state = S_LEN_HI;
                        w_hold  = 1'b1;
                        w_done  = 1'b0;
                        w_err   = 1'b0;
                        w_cnt   = '0;
                    end
                end
                S_LEN_HI: begin
                    w_len   = {bus.RX_DATA, 8'h00};
                    w_state = S_LEN_LO;
                end
                S_LEN_LO: begin
                    w_len = {r_len[15:8], bus.RX_DATA};
                    if (w_len == 16'd0 || {1'b0, w_len} > 17'(MAX_WORDS)) begin
                        w_state = S_IDLE;
                        w_err   = 1'b1;
                    end else begin
                        w_state = S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    w_hi    = bus.RX_DATA;
                    w_state = S_DATA_LO;
                end
                S_DATA_LO: begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_cnt;
                    w_wr_data = {r_hi, bus.RX_DATA};
                    w_cnt     = r_cnt + 16'd1;
                    w_state   = S_DATA_HI;
                    // Last word: the status update lands on the same edge as its write strobe.
                    if (r_cnt == r_len - 16'd1) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        w_state = S_CHECK;
`else
                        w_state = S_IDLE;
                        w_done  = 1'b1;
                        w_hold  = 1'b0;
`endif
                    end
                end
`ifdef ROM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    w_state = S_IDLE;
                    w_done  = (r_csum == bus.RX_DATA);
                    w_hold  = (r_csum != bus.RX_DATA);
                    w_err   = (r_csum != bus.RX_DATA);
                end
`endif
                default: w_state = S_IDLE;
            endcase
        end else if (r_state != S_IDLE && r_tmo == TMO_LAST) begin
            w_state = S_IDLE;
            w_err   = 1'b1;
        end
    end

    assign bus.WR_EN     = r_wr_en;
    assign bus.WR_ADDR   = r_wr_addr;
    assign bus.WR_DATA   = r_wr_data;
    assign bus.CPU_HOLD  = r_hold;
    assign bus.LOAD_DONE = r_done;
    assign bus.LOAD_ERR  = r_err;
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed and random frames checked against a word-list model of the loader.
module tb_rom_loader;
    localparam int TMO  = 100;
    localparam int MAXW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    rom_loader_if bus();

    rom_loader #(.TIMEOUT_CYCLES(TMO), .MAX_WORDS(MAXW), .SYNC_BYTE(8'hA5)) dut (
        .CLK_100MHz(clk),
        .RESET_N(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] got[$];
    logic [15:0] words[$];

    always @(negedge clk) if (bus.WR_EN) got.push_back({bus.WR_ADDR, bus.WR_DATA});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        bus.RX_DATA  = b;
        bus.RX_VALID = 1'b1;
        @(negedge clk);
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = 8'($urandom);
    endtask

    task automatic send_words(input int gmin, input int gmax);
        int n;
        logic [7:0] cs;
        n  = words.size();
        cs = n[15:8] ^ n[7:0];
        send_byte(8'hA5, 0);
        send_byte(n[15:8], $urandom_range(gmax, gmin));
        send_byte(n[7:0], $urandom_range(gmax, gmin));
        foreach (words[i]) begin
            send_byte(words[i][15:8], $urandom_range(gmax, gmin));
            send_byte(words[i][7:0], $urandom_range(gmax, gmin));
            cs = cs ^ words[i][15:8] ^ words[i][7:0];
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        send_byte(cs, $urandom_range(gmax, gmin));
`endif
    endtask

    task automatic status(input string tag, input logic [2:0] exp);
        chk(tag, 64'({bus.CPU_HOLD, bus.LOAD_DONE, bus.LOAD_ERR}), 64'(exp));
    endtask

    // Every loaded word must appear once, in order, at its index.
    task automatic expect_writes(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_nwr"}, 64'(got.size()), 64'(words.size()));
        foreach (words[i]) if (i < got.size()) chk({tag, "_wr"}, 64'(got[i]), 64'({16'(i), words[i]}));
        got.delete();
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(($urandom_range(3, 0) == 0) ? 16'hA5A5 : 16'($urandom));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.RX_DATA  = 8'h00;
        bus.RX_VALID = 1'b0;
        #2;
        chk("reset_out", 64'({bus.WR_EN, bus.WR_ADDR, bus.WR_DATA, bus.CPU_HOLD, bus.LOAD_DONE, bus.LOAD_ERR}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h37, 0);
        send_byte(8'h00, 2);
        status("idle_noise", 3'b000);

        words = '{16'h1234, 16'hABCD};
        send_byte(8'hA5, 0);
        status("loading", 3'b100);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 1);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 3);
        send_byte(8'hCD, 0);
`ifndef ROM_LOADER_CHECKSUM_EN
        chk("wr_timing", 64'({bus.WR_EN, bus.WR_ADDR, bus.WR_DATA}), 64'({1'b1, 16'd1, 16'hABCD}));
`else
        send_byte(8'h42, 0);
`endif
        expect_writes("basic");
        status("basic_st", 3'b010);

        words.delete();
        send_words(0, 0);
        expect_writes("len0");
        status("len0_st", 3'b101);
        rand_words(3);
        send_words(0, 2);
        expect_writes("recover");
        status("recover_st", 3'b010);

        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'(MAXW + 1), 0);
        words.delete();
        expect_writes("over");
        status("over_st", 3'b101);
        rand_words(MAXW);
        send_words(0, 1);
        expect_writes("maxw");
        status("maxw_st", 3'b010);

`ifndef ROM_LOADER_CHECKSUM_EN
        send_byte(8'h5A, 0);
        words.delete();
        expect_writes("trail");
        status("trail_st", 3'b010);
`else
        words = '{16'hA5A5};
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hA5, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        expect_writes("badsum");
        status("badsum_st", 3'b101);
`endif

        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        repeat (TMO - 1) @(negedge clk);
        status("tmo_early", 3'b100);
        @(negedge clk);
        status("tmo_fire", 3'b101);
        words.delete();
        expect_writes("tmo");

        words = '{16'h1234};
        send_words(TMO - 1, TMO - 1);
        expect_writes("gapmax");
        status("gapmax_st", 3'b010);

        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out", 64'({bus.WR_EN, bus.WR_ADDR, bus.WR_DATA, bus.CPU_HOLD, bus.LOAD_DONE, bus.LOAD_ERR}), 64'd0);
        words = '{16'h1122};
        @(negedge clk);
        expect_writes("rst_pre");
        rst_n = 1'b1;
        send_byte(8'h44, 1);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        words.delete();
        expect_writes("rst_stray");
        status("rst_st", 3'b000);

        for (int f = 0; f < 6; f++) begin
            rand_words($urandom_range(MAXW, 1));
            send_words(0, 4);
            expect_writes("rand");
            status("rand_st", 3'b010);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
